maxpool_l1: RTL and testbench

Layer-1 stage of the image convolution circuit. Once the convolution stage has filled the 64x64 layer-0 memory (conv + bias + ReLU), this block reads layer 0 through the shared memory port, applies 2x2 max pooling with stride 2, and writes the 32x32 result to layer-1 memory. It is started by a single-cycle pulse and signals completion with `done`.

---
 rtl/maxpool_l1.sv | 173 +++++++++++++++++
 tb/tb_maxpool_l1.sv | 172 +++++++++++++++++
 2 files changed

// File: rtl/maxpool_l1.sv
//============================================================================
// Module   : maxpool_l1
// Purpose  : 2x2 stride-2 signed max pooling, 64x64 layer-0 -> 32x32 layer-1
// Revision : 1.0  initial release
//============================================================================
`default_nettype none

module maxpool_l1 #(
    parameter int         DW     = 20,
    parameter logic [2:0] L0_SEL = 3'd1,
    parameter logic [2:0] L1_SEL = 3'd3
) (
    input  logic          clk,
    input  logic          reset_n,
    input  logic          start,
    output logic          busy,
    output logic          done,
    output logic          crd,
    output logic [11:0]   caddr_rd,
    input  logic [DW-1:0] cdata_rd,
    output logic          cwr,
    output logic [11:0]   caddr_wr,
    output logic [DW-1:0] cdata_wr,
    output logic [2:0]    csel
);

    typedef enum logic [2:0] {
        S_IDLE = 3'd0,
        S_R0   = 3'd1,
        S_R1   = 3'd2,
        S_R2   = 3'd3,
        S_R3   = 3'd4,
        S_R4   = 3'd5,
        S_W    = 3'd6,
        S_DONE = 3'd7
    } state_t;

    state_t        state_q, state_d;
    logic [4:0]    py_q, py_d;
    logic [4:0]    px_q, px_d;
    logic [DW-1:0] max_q, max_d;
    logic          busy_q, busy_d;
    logic          done_q, done_d;
    logic          crd_q, crd_d;
    logic          cwr_q, cwr_d;
    logic [11:0]   caddr_rd_q, caddr_rd_d;
    logic [11:0]   caddr_wr_q, caddr_wr_d;
    logic [DW-1:0] cdata_wr_q, cdata_wr_d;
    logic [2:0]    csel_q, csel_d;
    logic          row_bit, col_bit;

    function automatic logic [DW-1:0] smax(input logic [DW-1:0] a, input logic [DW-1:0] b);
        return ($signed(a) > $signed(b)) ? a : b;
    endfunction

    always_comb begin
        state_d    = state_q;
        py_d       = py_q;
        px_d       = px_q;
        max_d      = max_q;
        crd_d      = 1'b0;
        cwr_d      = 1'b0;
        done_d     = 1'b0;
        caddr_rd_d = caddr_rd_q;
        caddr_wr_d = caddr_wr_q;
        cdata_wr_d = cdata_wr_q;
        csel_d     = csel_q;
        row_bit    = 1'b0;
        col_bit    = 1'b0;

        // Read data arrives one cycle late, so the sample for Rk is taken leaving R(k+1).
        case (state_q)
            S_IDLE: begin
                if (start) begin
                    state_d = S_R0;
                    py_d    = 5'd0;
                    px_d    = 5'd0;
                end
            end
            S_R0: state_d = S_R1;
            S_R1: begin
                state_d = S_R2;
                max_d   = cdata_rd;
            end
            S_R2: begin
                state_d = S_R3;
                max_d   = smax(max_q, cdata_rd);
            end
            S_R3: begin
                state_d = S_R4;
                max_d   = smax(max_q, cdata_rd);
            end
            S_R4: begin
                state_d    = S_W;
                cdata_wr_d = smax(max_q, cdata_rd);
                caddr_wr_d = {2'b00, py_q, px_q};
            end
            S_W: begin
                {py_d, px_d} = {py_q, px_q} + 10'd1;
                state_d      = (py_q == 5'd31 && px_q == 5'd31) ? S_DONE : S_R0;
            end
            S_DONE: state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase

        // Outputs are registered, so they are decoded from the state being entered.
        case (state_d)
            S_R0: begin row_bit = 1'b0; col_bit = 1'b0; end
            S_R1: begin row_bit = 1'b0; col_bit = 1'b1; end
            S_R2: begin row_bit = 1'b1; col_bit = 1'b0; end
            S_R3: begin row_bit = 1'b1; col_bit = 1'b1; end
            default: begin row_bit = 1'b0; col_bit = 1'b0; end
        endcase

        case (state_d)
            S_R0, S_R1, S_R2, S_R3: begin
                crd_d      = 1'b1;
                csel_d     = L0_SEL;
                caddr_rd_d = {py_d, row_bit, px_d, col_bit};
            end
            S_W: begin
                cwr_d  = 1'b1;
                csel_d = L1_SEL;
            end
            S_DONE: done_d = 1'b1;
            default: ;
        endcase

        busy_d = (state_d != S_IDLE);
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q    <= S_IDLE;
            py_q       <= 5'd0;
            px_q       <= 5'd0;
            max_q      <= '0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            crd_q      <= 1'b0;
            cwr_q      <= 1'b0;
            caddr_rd_q <= 12'd0;
            caddr_wr_q <= 12'd0;
            cdata_wr_q <= '0;
            csel_q     <= 3'd0;
        end else begin
            state_q    <= state_d;
            py_q       <= py_d;
            px_q       <= px_d;
            max_q      <= max_d;
            busy_q     <= busy_d;
            done_q     <= done_d;
            crd_q      <= crd_d;
            cwr_q      <= cwr_d;
            caddr_rd_q <= caddr_rd_d;
            caddr_wr_q <= caddr_wr_d;
            cdata_wr_q <= cdata_wr_d;
            csel_q     <= csel_d;
        end
    end

    assign busy     = busy_q;
    assign done     = done_q;
    assign crd      = crd_q;
    assign cwr      = cwr_q;
    assign caddr_rd = caddr_rd_q;
    assign caddr_wr = caddr_wr_q;
    assign cdata_wr = cdata_wr_q;
    assign csel     = csel_q;

endmodule

`default_nettype wire

// File: tb/tb_maxpool_l1.sv
//============================================================================
// Module   : tb_maxpool_l1
// Purpose  : directed self-checking bench for maxpool_l1 with a layer-0 model
// Revision : 1.0  initial release
//============================================================================
`default_nettype none

module tb_maxpool_l1;

    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic        start = 1'b0;
    logic        busy, done, crd, cwr;
    logic [11:0] caddr_rd, caddr_wr;
    logic [19:0] cdata_rd = '0;
    logic [19:0] cdata_wr;
    logic [2:0]  csel;

    logic [19:0] l0 [4096];
    logic [19:0] l1 [1024];
    int checks = 0;
    int failures = 0;

    maxpool_l1 #(.DW(20), .L0_SEL(3'd1), .L1_SEL(3'd3)) dut (
        .clk(clk), .reset_n(reset_n), .start(start), .busy(busy), .done(done),
        .crd(crd), .caddr_rd(caddr_rd), .cdata_rd(cdata_rd), .cwr(cwr),
        .caddr_wr(caddr_wr), .cdata_wr(cdata_wr), .csel(csel)
    );

    always #5 clk = ~clk;

    // Layer-0 memory: one-cycle read latency, garbage when not read.
    always @(posedge clk) begin
        if (crd) cdata_rd <= l0[caddr_rd];
        else     cdata_rd <= 20'($urandom);
    end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [19:0] pool(input int p);
        int py, px, m, v;
        py = p / 32;
        px = p % 32;
        m  = $signed(l0[(2*py)*64 + 2*px]);
        for (int r = 0; r < 2; r++)
            for (int c = 0; c < 2; c++) begin
                v = $signed(l0[(2*py+r)*64 + 2*px + c]);
                if (v > m) m = v;
            end
        return m[19:0];
    endfunction

    function automatic logic [63:0] all_outs();
        return {13'd0, busy, done, crd, cwr, caddr_rd, caddr_wr, cdata_wr, csel};
    endfunction

    task automatic load_ramp();
        for (int a = 0; a < 4096; a++) l0[a] = 20'(a);
    endtask

    // Full run from a start pulse; cycle n is the n-th cycle after the accepting edge.
    task automatic run_check(input bit hs);
        int wcount, rcount, done_cnt, done_cyc, first_wr, extra, bad_rd;
        wcount = 0; rcount = 0; done_cnt = 0; done_cyc = 0; first_wr = 0; extra = 0; bad_rd = 0;
        @(negedge clk) start = 1'b1;
        for (int n = 1; n <= 6160; n++) begin
            @(negedge clk);
            if (cwr) begin
                if (wcount == 0) first_wr = n;
                chk("wr_addr", {52'd0, caddr_wr}, 64'(wcount));
                chk("wr_data", {44'd0, cdata_wr}, {44'd0, pool(wcount)});
                chk("wr_csel", {61'd0, csel}, 64'd3);
                l1[caddr_wr[9:0]] = cdata_wr;
                wcount++;
            end
            if (crd) begin
                rcount++;
                if (csel !== 3'd1) bad_rd++;
            end
            if (done) begin
                done_cnt++;
                done_cyc = n;
            end
            if (n == 6145) chk("busy_done_cycle", {63'd0, busy}, 64'd1);
            if (n > 6145 && (crd || cwr || busy || done)) extra++;
            start = hs && (n == 3 || n == 3000 || n == 6145);
        end
        start = 1'b0;
        chk("write_count", 64'(wcount), 64'd1024);
        chk("read_count", 64'(rcount), 64'd4096);
        chk("read_csel", 64'(bad_rd), 64'd0);
        chk("first_wr_cycle", 64'(first_wr), 64'd6);
        chk("done_count", 64'(done_cnt), 64'd1);
        chk("done_cycle", 64'(done_cyc), 64'd6145);
        chk("quiet_after_done", 64'(extra), 64'd0);
    endtask

    initial begin
        int noisy;
        load_ramp();

        // Reset with random start activity
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            start = 1'($urandom_range(0, 1));
            chk("reset_outputs", all_outs(), 64'd0);
        end
        start = 1'b0;
        reset_n = 1'b1;
        noisy = 0;
        for (int i = 0; i < 100; i++) begin
            @(negedge clk);
            if (all_outs() !== 64'd0) noisy++;
        end
        chk("idle_100_cycles", 64'(noisy), 64'd0);

        // Ramp image with extra start pulses in cycles 3, 3000, 6145
        run_check(1'b1);
        chk("ramp_l1_0", {44'd0, l1[0]}, 64'd65);
        chk("ramp_l1_1", {44'd0, l1[1]}, 64'd67);
        chk("ramp_l1_32", {44'd0, l1[32]}, 64'd193);
        chk("ramp_l1_1023", {44'd0, l1[1023]}, 64'd4095);

        // Negative block, max-position sweep, all-equal window
        l0[0] = 20'hFFFFB; l0[1] = 20'hFFFFD; l0[64] = 20'hFFFF9; l0[65] = 20'hFFFFF;
        for (int k = 0; k < 4; k++) begin
            l0[2*(k+1)]      = (k == 0) ? 20'h7FFFF : 20'h80000;
            l0[2*(k+1)+1]    = (k == 1) ? 20'h7FFFF : 20'h80000;
            l0[64+2*(k+1)]   = (k == 2) ? 20'h7FFFF : 20'h80000;
            l0[64+2*(k+1)+1] = (k == 3) ? 20'h7FFFF : 20'h80000;
        end
        l0[10] = 20'h00123; l0[11] = 20'h00123; l0[74] = 20'h00123; l0[75] = 20'h00123;
        run_check(1'b0);
        chk("neg_block", {44'd0, l1[0]}, 64'hFFFFF);
        chk("sweep_pos0", {44'd0, l1[1]}, 64'h7FFFF);
        chk("sweep_pos1", {44'd0, l1[2]}, 64'h7FFFF);
        chk("sweep_pos2", {44'd0, l1[3]}, 64'h7FFFF);
        chk("sweep_pos3", {44'd0, l1[4]}, 64'h7FFFF);
        chk("equal_window", {44'd0, l1[5]}, 64'h00123);

        // Reset during the write cycle of pixel 100 (cycle 606)
        load_ramp();
        @(negedge clk) start = 1'b1;
        @(negedge clk) start = 1'b0;
        repeat (605) @(negedge clk);
        chk("w_pixel100_cwr", {63'd0, cwr}, 64'd1);
        chk("w_pixel100_addr", {52'd0, caddr_wr}, 64'd100);
        #1 reset_n = 1'b0;
        #1 chk("async_reset_outs", all_outs(), 64'd0);
        repeat (2) @(negedge clk);
        reset_n = 1'b1;
        noisy = 0;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            if (all_outs() !== 64'd0) noisy++;
        end
        chk("idle_after_reset", 64'(noisy), 64'd0);
        run_check(1'b0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

`default_nettype wire
